lfsr_checker: RTL and testbench
===============================

// Module: lfsr_checker
// PURPOSE
//   Receive-side checker for the 8-bit XNOR LFSR bit stream (taps 8,6,5,4).
//   Self-synchronises by loading 8 received bits, then predicts each next bit,
//   flags and counts mismatches, and drops lock on excessive errors.
//   Sits at the far end of a link or datapath driven by the LFSR generator,
//   and is used for BER and link checks.
// PARAMETERS
//   WINDOW      64  compared bits per loss-of-lock window (>= ERR_THRESH)
//   ERR_THRESH  8   errors within one window that force loss of lock (>= 1)
//   CNT_W       16  width of err_count_o / bit_count_o
// PORTS
//   clk_i        in   1      clock; all logic on posedge
//   rst_i        in   1      synchronous, active-high reset
//   en_i         in   1      bit_i valid this cycle; nothing advances when low
//   bit_i        in   1      received stream bit
//   clr_i        in   1      clear err_count_o and bit_count_o; lock unaffected
//   locked_o     out  1      checker synchronised (registered)
//   err_o        out  1      1-cycle pulse: previous compared bit mismatched
//   err_count_o  out  CNT_W  saturating mismatch count
//   bit_count_o  out  CNT_W  saturating compared-bit count
// BEHAVIOUR
//   Reset: state=SEED, shreg=0, fill=0, window counters=0.
//     All outputs are 0 in the cycle after rst_i is sampled high.
//   rst_i overrides everything, including mid-lock.
//   shreg[7:0] holds stream history, newest bit in [0]; shift is {shreg[6:0],x}.
//   pred = ~(shreg[7]^shreg[5]^shreg[4]^shreg[3]) (== chained ^~ of taps).
//   en_i=0: no state, counter or shreg change; err_o=0 next cycle.
//   SEED (en_i=1): shift in bit_i; fill saturates at 8.
//     Go to LOCKED when the post-shift fill==8 and post-shift shreg!=8'hFF.
//     8'hFF is the XNOR lockup state: stay in SEED and keep shifting.
//     No compares, counts or err_o while in SEED.
//   LOCKED (en_i=1): compare bit_i with pred; mm = (bit_i != pred).
//     Shift in pred, not bit_i (flywheel), so one corrupted bit = one error.
//     err_o <= mm (registered, 1-cycle latency).
//     bit_count += 1 and err_count += mm, both saturating at all-ones.
//   Loss of lock, evaluated on each compared bit:
//     If win_err+mm >= ERR_THRESH: state<=SEED, fill<=0, clear win_cnt/win_err.
//       err_o still pulses for that bit; counters keep their values.
//     Else if win_cnt==WINDOW-1: clear win_cnt/win_err (new window).
//     Else: win_cnt+=1, win_err+=mm.
//   locked_o <= (next state==LOCKED): rises the cycle after the 8th seed bit
//     and falls the cycle after the bit that crosses the threshold.
//   clr_i: both counters <= 0, taking priority over a same-cycle increment.
//     err_o, lock state and window counters are unaffected by clr_i.
//   First compared bit = the first en_i bit after locking (the 9th bit on a
//     clean stream).
// TESTING
//   1 rst; generator(seed 0) -> bit_i, en_i=1:
//     locked_o=1 after 8 bits; +100 bits -> err_count_o=0, bit_count_o=100.
//   2 Locked clean stream, invert compared bit #20 only:
//     err_o single pulse, err_count_o=1, locked_o stays 1, no later errors.
//   3 bit_i=1 constantly for 50 en cycles:
//     locked_o stays 0 (8'hFF lockup), counters stay 0.
//   4 Locked, invert 8 consecutive bits:
//     err_count_o=8, locked_o falls after the 8th; clean stream -> relock
//     8 en cycles later.
//   5 en_i toggled every cycle, random bit_i while en_i=0:
//     lock after 8 enabled bits, zero errors over 200 enabled bits.
//   6 clr_i on the same cycle as a mismatch -> err_count_o=0, err_o=1.
//     rst_i while locked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit XNOR LFSR stream (taps 8,6,5,4): self-seeds from
// the incoming bits, then flywheels its own prediction and counts mismatches.
module lfsr_checker #(
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] bit_count_o
);

  localparam int WC_W = $clog2(WINDOW + 1);
  localparam int WE_W = $clog2(ERR_THRESH + 1);

  typedef enum logic {
    SEED   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q;
  logic [7:0]       shreg_q;
  logic [3:0]       fill_q;
  logic [WC_W-1:0]  win_cnt_q;
  logic [WE_W-1:0]  win_err_q;
  logic             locked_q;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] bit_cnt_q;

  logic             pred;
  logic             mm;
  logic [7:0]       seed_shreg_d;
  logic [3:0]       fill_d;
  logic             seed_done;
  logic [WE_W:0]    win_err_d;
  logic             lose_lock;
  logic             win_last;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    pred         = ~(shreg_q[7] ^ shreg_q[5] ^ shreg_q[4] ^ shreg_q[3]);
    mm           = (bit_i != pred);
    seed_shreg_d = {shreg_q[6:0], bit_i};
    fill_d       = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
    // All-ones is the XNOR lockup state; it can never be a valid seed.
    seed_done    = (fill_d == 4'd8) && (seed_shreg_d != 8'hFF);
    win_err_d    = {1'b0, win_err_q} + {{WE_W{1'b0}}, mm};
    lose_lock    = (win_err_d >= (WE_W + 1)'(ERR_THRESH));
    win_last     = (win_cnt_q == WC_W'(WINDOW - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= SEED;
      shreg_q   <= 8'h00;
      fill_q    <= 4'd0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (en_i) begin
        case (state_q)
          SEED: begin
            shreg_q <= seed_shreg_d;
            fill_q  <= fill_d;
            if (seed_done) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            // Flywheel: history follows the prediction so a single bad bit costs one error.
            shreg_q   <= {shreg_q[6:0], pred};
            err_q     <= mm;
            bit_cnt_q <= sat_inc(bit_cnt_q, 1'b1);
            err_cnt_q <= sat_inc(err_cnt_q, mm);
            if (lose_lock) begin
              state_q   <= SEED;
              locked_q  <= 1'b0;
              fill_q    <= 4'd0;
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else if (win_last) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + WC_W'(1);
              win_err_q <= win_err_d[WE_W-1:0];
            end
          end
          default: begin
            state_q  <= SEED;
            locked_q <= 1'b0;
          end
        endcase
      end
      // Clear wins over any increment made above in the same cycle.
      if (clr_i) begin
        err_cnt_q <= '0;
        bit_cnt_q <= '0;
      end
    end
  end

  assign locked_o    = locked_q;
  assign err_o       = err_q;
  assign err_count_o = err_cnt_q;
  assign bit_count_o = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: a bit-history reference model fills a scoreboard queue that a
// separate monitor drains every cycle, plus directed checks of the key scenarios.
module tb_lfsr_checker;

  localparam int WIN   = 64;
  localparam int TH    = 8;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          en_i = 1'b0;
  logic          bit_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          locked_o;
  logic          err_o;
  logic [CW-1:0] err_count_o;
  logic [CW-1:0] bit_count_o;

  always #5 clk = ~clk;

  lfsr_checker #(.WINDOW(WIN), .ERR_THRESH(TH), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .bit_i(bit_i), .clr_i(clr_i),
    .locked_o(locked_o), .err_o(err_o), .err_count_o(err_count_o), .bit_count_o(bit_count_o)
  );

  typedef struct {
    bit locked;
    bit err;
    int ecnt;
    int bcnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: last 8 stream bits, oldest first.
  bit m_hist[$];
  int m_locked, m_fill, m_wcnt, m_werr, m_ecnt, m_bcnt;
  bit m_err;
  // Transmit-side generator history.
  bit g_hist[$];

  // Stream recurrence b[n] = ~(b[n-8] ^ b[n-6] ^ b[n-5] ^ b[n-4]).
  function automatic bit lfsr_next(input bit h[$]);
    return ~(h[0] ^ h[2] ^ h[3] ^ h[4]);
  endfunction

  task automatic gen_reset();
    g_hist = '{0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic gen(output bit b);
    b = lfsr_next(g_hist);
    g_hist.push_back(b);
    void'(g_hist.pop_front());
  endtask

  task automatic model(input bit r, input bit e, input bit b, input bit c);
    bit p, mis;
    int ones;
    if (r) begin
      m_hist = '{0, 0, 0, 0, 0, 0, 0, 0};
      m_locked = 0; m_fill = 0; m_wcnt = 0; m_werr = 0;
      m_ecnt = 0; m_bcnt = 0; m_err = 0;
      return;
    end
    m_err = 0;
    if (e) begin
      if (m_locked == 0) begin
        m_hist.push_back(b);
        void'(m_hist.pop_front());
        if (m_fill < 8) m_fill++;
        ones = 0;
        foreach (m_hist[i]) ones += int'(m_hist[i]);
        if (m_fill == 8 && ones != 8) m_locked = 1;
      end else begin
        p   = lfsr_next(m_hist);
        mis = (b != p);
        m_hist.push_back(p);
        void'(m_hist.pop_front());
        m_err = mis;
        if (m_bcnt < CMAX) m_bcnt++;
        if (mis && m_ecnt < CMAX) m_ecnt++;
        if (m_werr + int'(mis) >= TH) begin
          m_locked = 0; m_fill = 0; m_wcnt = 0; m_werr = 0;
        end else if (m_wcnt == WIN - 1) begin
          m_wcnt = 0; m_werr = 0;
        end else begin
          m_wcnt++;
          m_werr += int'(mis);
        end
      end
    end
    if (c) begin
      m_ecnt = 0;
      m_bcnt = 0;
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input bit r, input bit e, input bit b, input bit c);
    exp_t x;
    @(negedge clk);
    rst_i = r; en_i = e; bit_i = b; clr_i = c;
    model(r, e, b, c);
    x.locked = (m_locked != 0);
    x.err    = m_err;
    x.ecnt   = m_ecnt;
    x.bcnt   = m_bcnt;
    sb.push_back(x);
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clean(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      gen(b);
      step(0, 1, b, 0);
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    gen_reset();
  endtask

  // Monitor: compares every presented output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (locked_o !== e.locked || err_o !== e.err ||
            int'(err_count_o) != e.ecnt || int'(bit_count_o) != e.bcnt) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got locked=%0b err=%0b ecnt=%0d bcnt=%0d, expected locked=%0b err=%0b ecnt=%0d bcnt=%0d",
                   $time, locked_o, err_o, err_count_o, bit_count_o, e.locked, e.err, e.ecnt, e.bcnt);
        end
      end
    end
  end

  initial begin
    bit b, en, fl, cl, rr;
    m_hist = '{0, 0, 0, 0, 0, 0, 0, 0};
    gen_reset();

    // Reset values and clean lock-up from seed 0.
    do_reset();
    sync();
    chk("reset_locked", int'(locked_o), 0);
    chk("reset_err", int'(err_o), 0);
    chk("reset_ecnt", int'(err_count_o), 0);
    chk("reset_bcnt", int'(bit_count_o), 0);
    clean(7);
    sync();
    chk("seed7_not_locked", int'(locked_o), 0);
    clean(1);
    sync();
    chk("seed8_locked", int'(locked_o), 1);
    clean(100);
    sync();
    chk("clean_bcnt", int'(bit_count_o), 100);
    chk("clean_ecnt", int'(err_count_o), 0);

    // Single corrupted bit: one error, lock held.
    clean(19);
    gen(b);
    step(0, 1, ~b, 0);
    sync();
    chk("single_err_pulse", int'(err_o), 1);
    clean(1);
    sync();
    chk("single_err_cleared", int'(err_o), 0);
    clean(30);
    sync();
    chk("single_ecnt", int'(err_count_o), 1);
    chk("single_locked", int'(locked_o), 1);

    // Constant ones: lockup pattern must never lock.
    do_reset();
    for (int i = 0; i < 50; i++) step(0, 1, 1, 0);
    sync();
    chk("ones_not_locked", int'(locked_o), 0);
    chk("ones_bcnt", int'(bit_count_o), 0);
    chk("ones_ecnt", int'(err_count_o), 0);

    // Burst of 8 errors drops lock; clean stream relocks 8 bits later.
    do_reset();
    clean(38);
    for (int i = 0; i < 7; i++) begin
      gen(b);
      step(0, 1, ~b, 0);
    end
    sync();
    chk("burst7_locked", int'(locked_o), 1);
    gen(b);
    step(0, 1, ~b, 0);
    sync();
    chk("burst8_unlocked", int'(locked_o), 0);
    chk("burst_ecnt", int'(err_count_o), 8);
    clean(7);
    sync();
    chk("relock7_not_yet", int'(locked_o), 0);
    clean(1);
    sync();
    chk("relock8_locked", int'(locked_o), 1);

    // Alternating enable with garbage on idle cycles.
    do_reset();
    for (int i = 0; i < 208; i++) begin
      step(0, 0, 1'($urandom_range(0, 1)), 0);
      gen(b);
      step(0, 1, b, 0);
    end
    sync();
    chk("gated_locked", int'(locked_o), 1);
    chk("gated_bcnt", int'(bit_count_o), 200);
    chk("gated_ecnt", int'(err_count_o), 0);

    // Clear coincident with a mismatch, then reset while locked.
    clean(10);
    gen(b);
    step(0, 1, ~b, 1);
    sync();
    chk("clr_mm_err", int'(err_o), 1);
    chk("clr_mm_ecnt", int'(err_count_o), 0);
    chk("clr_mm_locked", int'(locked_o), 1);
    step(1, 0, 0, 0);
    sync();
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_ecnt", int'(err_count_o), 0);
    chk("rst_bcnt", int'(bit_count_o), 0);

    // Randomized traffic: gaps, sparse then dense errors, occasional clear and reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 149) == 0);
      rr = ($urandom_range(0, 799) == 0);
      if (en) begin
        gen(b);
        fl = (i < 1500) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 4) == 0);
        step(rr, 1, b ^ fl, cl);
      end else begin
        step(rr, 0, 1'($urandom_range(0, 1)), cl);
      end
    end

    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
